dwt_haar_multilevel_ctrl: RTL

Sequencer for a multi-level 1-D Haar DWT built on one shared, purely combinational Haar pair core (181/256 scaling, Q8.8 in and out). On `start` it captures an N-sample frame into an internal buffer and feeds sample pairs to the core, one pair every two cycles. After each level it recycles the approximation coefficients (cA) as the input to the next level, for LEVELS levels. It sits between the frame source and the pair core and presents the result in Mallat order: [cA_final, cD_L, …, cD_1].

---
 rtl/dwt_haar_multilevel_ctrl.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/dwt_haar_multilevel_ctrl.sv
// Multi-level 1-D Haar DWT sequencer around an external combinational pair core.
// Optional build macro DWT_ML_ABORT_EN adds an abort input that returns the FSM to IDLE.
module dwt_haar_multilevel_ctrl #(
  parameter int N      = 8,
  parameter int LEVELS = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [N*16-1:0]              array_in,
  output logic [15:0]                  core_x0,
  output logic [15:0]                  core_x1,
  input  logic [15:0]                  core_cA,
  input  logic [15:0]                  core_cD,
  output logic [N*16-1:0]              coeff_out,
  output logic [$clog2(LEVELS+1)-1:0]  level,
  output logic                         busy,
  output logic                         done
`ifdef DWT_ML_ABORT_EN
  ,
  input  logic                         abort
`endif
);

  localparam int KW  = $clog2(N);
  localparam int LW  = KW + 1;
  localparam int LVW = $clog2(LEVELS + 1);
  localparam int NF  = N >> LEVELS;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_CAPTURE,
    S_NEXT_LVL,
    S_FINISH
  } state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic [15:0]          r_buf [N];
  logic [LW-1:0]        r_len;
  logic [KW-1:0]        r_k;
  logic [LVW-1:0]       r_level;
  logic [15:0]          r_x0;
  logic [15:0]          r_x1;
  logic [N*16-1:0]      r_coeff;

  logic [LW-1:0]        w_half;
  logic [LW-1:0]        w_half_m1;
  logic [LW-1:0]        w_slot;
  logic [KW+3:0]        w_slot_lsb;
  logic [KW-1:0]        w_even;
  logic [KW-1:0]        w_odd;
  logic                 w_last;
  logic                 w_last_level;
  logic                 w_abort;
  logic                 w_busy;
  logic                 w_done;

`ifdef DWT_ML_ABORT_EN
  assign w_abort = abort && (r_state != S_IDLE);
`else
  assign w_abort = 1'b0;
`endif

  // Pair k reads buf[2k], buf[2k+1]; its detail lands in slot len/2 + k.
  assign w_half       = r_len >> 1;
  assign w_half_m1    = w_half - LW'(1);
  assign w_last       = (LW'(r_k) == w_half_m1);
  assign w_last_level = (r_level == LVW'(LEVELS));
  assign w_slot       = w_half + LW'(r_k);
  assign w_slot_lsb   = {w_slot[KW-1:0], 4'b0000};
  assign w_even       = KW'({r_k, 1'b0});
  assign w_odd        = w_even + KW'(1);

  // NOTE: sequential state is written with <= only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // NOTE: every output of this block gets a default first, so no path infers a latch.
  always_comb begin
    w_next_state = r_state;
    w_busy       = (r_state != S_IDLE);
    w_done       = 1'b0;
    case (r_state)
      S_IDLE:     if (start) w_next_state = S_LOAD;
      S_LOAD:     w_next_state = S_ISSUE;
      S_ISSUE:    w_next_state = S_CAPTURE;
      S_CAPTURE:  w_next_state = w_last ? S_NEXT_LVL : S_ISSUE;
      S_NEXT_LVL: w_next_state = w_last_level ? S_FINISH : S_ISSUE;
      S_FINISH: begin
        w_done       = 1'b1;
        w_next_state = S_IDLE;
      end
      default:    w_next_state = S_IDLE;
    endcase
    if (w_abort) begin
      w_next_state = S_IDLE;
      w_done       = 1'b0;
    end
  end

  // NOTE: the sample buffer is cleared on reset as well, so it never holds stale frame data.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) r_buf[i] <= '0;
      r_len   <= '0;
      r_k     <= '0;
      r_level <= '0;
      r_x0    <= '0;
      r_x1    <= '0;
      r_coeff <= '0;
    end else if (w_abort) begin
      r_level <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            for (int i = 0; i < N; i++) r_buf[i] <= array_in[i*16 +: 16];
            r_len   <= LW'(N);
            r_level <= LVW'(1);
            r_k     <= '0;
          end
        end
        S_LOAD: r_coeff <= '0;
        S_ISSUE: begin
          r_x0 <= r_buf[w_even];
          r_x1 <= r_buf[w_odd];
        end
        S_CAPTURE: begin
          // In-place cA write is safe: later pairs of this level read indices >= 2k+2.
          r_buf[r_k]                <= core_cA;
          r_coeff[w_slot_lsb +: 16] <= core_cD;
          if (!w_last) r_k <= r_k + KW'(1);
        end
        S_NEXT_LVL: begin
          if (!w_last_level) begin
            r_len   <= r_len >> 1;
            r_level <= r_level + LVW'(1);
            r_k     <= '0;
          end else begin
            for (int i = 0; i < NF; i++) r_coeff[i*16 +: 16] <= r_buf[i];
          end
        end
        S_FINISH: r_level <= '0;
        default: ;
      endcase
    end
  end

  assign core_x0   = r_x0;
  assign core_x1   = r_x1;
  assign coeff_out = r_coeff;
  assign level     = r_level;
  assign busy      = w_busy;
  assign done      = w_done;

endmodule
